mips_trace_monitor: RTL and testbench
=====================================

// Module: mips_trace_monitor
// PURPOSE
//  Synthesizable debug/trace unit for the multicycle MIPS core; replaces fixed-time bench stop with run control.
//  Captures one trace entry per retired instruction into a parametrised buffer; buffer is read out after halt.
//  Halts the core on PC breakpoints, cycle timeout or arithmetic overflow.
//  Sits beside mips; core stalls its pc_write while halt=1.
// PARAMETERS
//  DEPTH        16  trace entries, power of 2, >=2
//  NUM_BP       4   PC breakpoint channels, 1..8
//  CYC_W        16  width of cycle/retire counters and max_cycles
//  MODE         0   0 = stop-when-full (newest dropped, lost set), 1 = circular (oldest overwritten)
//  HALT_ON_OVF  1   1 = overflow at commit halts the core, 0 = overflow is only recorded
// PORTS
//  clk          in   1         system clock, rising edge
//  rst          in   1         asynchronous, active-high reset
//  commit_valid in   1         one-cycle pulse: instruction retires (controller returns to fetch)
//  commit_pc    in   32        PC of retiring instruction
//  gpr_we       in   1         GPR write strobe (any cycle of the instruction)
//  gpr_waddr    in   5         GPR write index
//  gpr_wdata    in   32        GPR write data
//  ovf          in   1         ALU overflow qualified by addi, sampled at commit
//  bp_en        in   NUM_BP    per-channel breakpoint enable
//  bp_addr      in   NUM_BP*32 breakpoint PCs, channel i at [32*i+:32]
//  max_cycles   in   CYC_W     timeout in cycles; 0 disables
//  clr          in   1         sync: flush buffer, zero counters, clear lost/cause, HALT->RUN
//  rd_req       in   1         pop head entry; ignored when rd_valid=0
//  rd_valid     out  1         buffer non-empty
//  rd_data      out  69        head entry, show-ahead: {ovf, we, waddr[4:0], pc[31:2], wdata[31:0]}
//  level        out  log2(DEPTH)+1  entries held
//  lost         out  1         sticky: an entry was dropped or overwritten
//  halt         out  1         core must stop
//  halt_cause   out  3         sticky: [0] breakpoint, [1] timeout, [2] overflow
//  cycle_cnt    out  CYC_W     cycles spent in RUN, saturating
//  retired_cnt  out  CYC_W     commits while RUN, saturating
// BEHAVIOUR
//  Reset: state RUN, all outputs 0, buffer empty, write latch cleared.
//  FSM RUN -> HALT on any halt condition; halt registered, asserted cycle after condition. HALT -> RUN only on clr.
//  Write latch: last gpr_we since previous commit held; we=0 and wdata=0 in entry if none. Cleared on each commit.
//  A gpr_we coinciding with commit_valid belongs to that commit.
//  Capture: commit_valid in RUN pushes one entry. Nothing pushed in HALT; latch still tracks writes.
//  Breakpoint: commit_pc == bp_addr[i] with bp_en[i] -> entry still pushed, cause[0] set, halt next cycle.
//  Timeout: in RUN, max_cycles!=0 and cycle_cnt==max_cycles-1 -> cause[1], halt next cycle. cycle_cnt then freezes.
//  Overflow: commit with ovf=1 and HALT_ON_OVF -> cause[2], halt next cycle.
//  Simultaneous conditions: set all applicable cause bits in the same cycle.
//  Full, push only: MODE 0 drops new entry; MODE 1 overwrites oldest and advances head. lost=1 in both modes.
//  Full, push+pop same cycle: both accepted, level stays DEPTH, lost unchanged.
//  Empty, push+pop: pop ignored, level becomes 1.
//  Reads are allowed in any state. Pointers wrap modulo DEPTH.
//  Counters saturate at all-ones and do not wrap.
//  clr has priority over push/pop in its cycle.
//  rst mid-operation: immediate return to reset values; buffer contents discarded.
// STRUCTURE
//  mips_dbg_defs.vh: entry field offsets/width (69), halt_cause bit indices, FSM encoding.
//  Sub-module trace_fifo: DEPTH x 69 RAM, head/tail/count, MODE overwrite logic.
//  Breakpoint compare, write latch, counters and FSM stay in top.
// TESTING
//  1. Reset, 5 commits pc=0x3000..0x3010, each writing $1..$5 = 1..5.
//     -> level=5; pops return pc[31:2]=0xC00..0xC04, waddr 1..5, wdata 1..5.
//  2. bp_addr[2]=0x3008, bp_en=4'b0100, run.
//     -> halt=1 one cycle after the 0x3008 commit; cause=3'b001; last entry pc 0x3008; later commits not captured.
//  3. max_cycles=300, no commits.
//     -> halt rises at cycle 300; cycle_cnt=299 frozen; cause=3'b010.
//  4. DEPTH=4, 6 commits, MODE 0 -> entries 1-4 held, lost=1; MODE 1 -> entries 3-6 held, lost=1.
//  5. Commit with ovf=1 at the same cycle as a breakpoint match.
//     -> cause=3'b101; clr -> halt=0, level=0, counters 0.
//  6. Full buffer, push+pop same cycle -> level stays DEPTH, lost stays 0. rst asserted mid-run -> all outputs 0 at once.

Source files
------------

// File: rtl/mips_trace_monitor_pkg.sv
// Shared definitions for the MIPS trace monitor: trace entry layout, halt cause bits, FSM encoding.
package mips_trace_monitor_pkg;

  localparam int ENTRY_W   = 69;
  localparam int CAUSE_W   = 3;
  localparam int CAUSE_BP  = 0;
  localparam int CAUSE_TO  = 1;
  localparam int CAUSE_OVF = 2;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  // Field order matches the packed rd_data word, MSB first.
  typedef struct packed {
    logic        ovf;
    logic        we;
    logic [4:0]  waddr;
    logic [29:0] pc;
    logic [31:0] wdata;
  } trace_entry_t;

endpackage

// File: rtl/mips_trace_monitor_trace_fifo.sv
// Trace buffer: show-ahead FIFO, push/pop resolve in one cycle, clr beats both.
// When full, MODE 0 drops the newest push and MODE 1 overwrites the oldest; either sets lost.
module mips_trace_monitor_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int MODE  = 0,
  parameter int W     = 69,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic          rd_vld_o,
  output logic [W-1:0]  rd_dat_o,
  output logic [AW:0]   level_o,
  output logic          lost_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          lost_q, lost_d;
  logic          full, pop_eff, wr_en, adv_head;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    pop_eff  = pop_i && (count_q != '0);
    wr_en    = push_i && (!full || pop_eff || (MODE == 1));
    // Overwrite in circular mode retires the oldest entry exactly like a pop.
    adv_head = pop_eff || (push_i && full && (MODE == 1));
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    lost_d   = lost_q;
    if (clr_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      lost_d  = 1'b0;
    end else begin
      if (wr_en)    tail_d = tail_q + AW'(1);
      if (adv_head) head_d = head_q + AW'(1);
      if (wr_en && !adv_head)      count_d = count_q + (AW+1)'(1);
      else if (adv_head && !wr_en) count_d = count_q - (AW+1)'(1);
      if (push_i && full && !pop_eff) lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      lost_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      lost_q  <= lost_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr_i) mem_q[tail_q] <= push_dat_i;
  end

  assign rd_vld_o = (count_q != '0);
  assign rd_dat_o = rd_vld_o ? mem_q[head_q] : '0;
  assign level_o  = count_q;
  assign lost_o   = lost_q;

endmodule

// File: rtl/mips_trace_monitor.sv
// Run control and retire trace for the multicycle MIPS core: breakpoints, cycle timeout, overflow halt.
// halt is registered (one cycle after the cause); trace reads are allowed in any state.
module mips_trace_monitor
  import mips_trace_monitor_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int NUM_BP      = 4,
  parameter int CYC_W       = 16,
  parameter int MODE        = 0,
  parameter int HALT_ON_OVF = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic                     gpr_we,
  input  logic [4:0]               gpr_waddr,
  input  logic [31:0]              gpr_wdata,
  input  logic                     ovf,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [NUM_BP*32-1:0]     bp_addr,
  input  logic [CYC_W-1:0]         max_cycles,
  input  logic                     clr,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     lost,
  output logic                     halt,
  output logic [CAUSE_W-1:0]       halt_cause,
  output logic [CYC_W-1:0]         cycle_cnt,
  output logic [CYC_W-1:0]         retired_cnt
);

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [4:0]         waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CAUSE_W-1:0] cause_q, cause_d, cause_set;
  logic [CYC_W-1:0]   cyc_q, cyc_d, ret_q, ret_d;
  logic               run, bp_hit, commit_run, to_hit;
  trace_entry_t       entry;

  always_comb begin
    run    = (state_q == S_RUN);
    bp_hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (commit_pc == bp_addr[32*i +: 32])) bp_hit = 1'b1;
    end
    commit_run = commit_valid && run;
    to_hit     = run && (max_cycles != '0) && (cyc_q == max_cycles - CYC_W'(1));
    cause_set            = '0;
    cause_set[CAUSE_BP]  = commit_run && bp_hit;
    cause_set[CAUSE_TO]  = to_hit;
    cause_set[CAUSE_OVF] = commit_run && ovf && (HALT_ON_OVF != 0);
  end

  // A write in the commit cycle belongs to that commit, so it bypasses the latch.
  always_comb begin
    entry.ovf   = ovf;
    entry.we    = gpr_we | we_q;
    entry.waddr = gpr_we ? gpr_waddr : waddr_q;
    entry.pc    = commit_pc[31:2];
    entry.wdata = gpr_we ? gpr_wdata : wdata_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (commit_valid) begin
      we_d    = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
    end else if (gpr_we) begin
      we_d    = 1'b1;
      waddr_d = gpr_waddr;
      wdata_d = gpr_wdata;
    end
  end

  always_comb begin
    cause_d = clr ? '0 : (cause_q | cause_set);
    cyc_d   = cyc_q;
    ret_d   = ret_q;
    if (clr) begin
      cyc_d = '0;
      ret_d = '0;
    end else begin
      if (run && !to_hit && !(&cyc_q)) cyc_d = cyc_q + CYC_W'(1);
      if (commit_run && !(&ret_q))     ret_d = ret_q + CYC_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (!clr && (|cause_set)) state_d = S_HALT;
      S_HALT:  if (clr) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    halt = (state_q == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cause_q <= '0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cause_q <= cause_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  mips_trace_monitor_trace_fifo #(
    .DEPTH (DEPTH),
    .MODE  (MODE),
    .W     (ENTRY_W)
  ) u_trace_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .push_i     (commit_run),
    .push_dat_i (entry),
    .pop_i      (rd_req),
    .rd_vld_o   (rd_valid),
    .rd_dat_o   (rd_data),
    .level_o    (level),
    .lost_o     (lost)
  );

  assign halt_cause  = cause_q;
  assign cycle_cnt   = cyc_q;
  assign retired_cnt = ret_q;

endmodule

// File: tb/tb_mips_trace_monitor.sv
// Directed bench: one 16-deep stop-when-full monitor plus 4-deep stop/circular monitors on shared stimulus.
module tb_mips_trace_monitor;
  import mips_trace_monitor_pkg::*;

  logic         clk, rst, commit_valid, gpr_we, ovf, clr, rd_req;
  logic [31:0]  commit_pc, gpr_wdata;
  logic [4:0]   gpr_waddr;
  logic [3:0]   bp_en;
  logic [127:0] bp_addr;
  logic [15:0]  max_cycles;

  logic               a_vld, b_vld, c_vld, a_lost, b_lost, c_lost, a_halt, b_halt, c_halt;
  logic [ENTRY_W-1:0] a_dat, b_dat, c_dat;
  logic [4:0]         a_lvl;
  logic [2:0]         b_lvl, c_lvl, a_cause, b_cause, c_cause;
  logic [15:0]        a_cyc, b_cyc, c_cyc, a_ret, b_ret, c_ret;

  int checks = 0;
  int failures = 0;

  mips_trace_monitor dut_a (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc), .gpr_we(gpr_we),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .ovf(ovf), .bp_en(bp_en), .bp_addr(bp_addr),
    .max_cycles(max_cycles), .clr(clr), .rd_req(rd_req), .rd_valid(a_vld), .rd_data(a_dat),
    .level(a_lvl), .lost(a_lost), .halt(a_halt), .halt_cause(a_cause), .cycle_cnt(a_cyc),
    .retired_cnt(a_ret));

  mips_trace_monitor #(.DEPTH(4), .MODE(0)) dut_b (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc), .gpr_we(gpr_we),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .ovf(ovf), .bp_en(bp_en), .bp_addr(bp_addr),
    .max_cycles(max_cycles), .clr(clr), .rd_req(rd_req), .rd_valid(b_vld), .rd_data(b_dat),
    .level(b_lvl), .lost(b_lost), .halt(b_halt), .halt_cause(b_cause), .cycle_cnt(b_cyc),
    .retired_cnt(b_ret));

  mips_trace_monitor #(.DEPTH(4), .MODE(1)) dut_c (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc), .gpr_we(gpr_we),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .ovf(ovf), .bp_en(bp_en), .bp_addr(bp_addr),
    .max_cycles(max_cycles), .clr(clr), .rd_req(rd_req), .rd_valid(c_vld), .rd_data(c_dat),
    .level(c_lvl), .lost(c_lost), .halt(c_halt), .halt_cause(c_cause), .cycle_cnt(c_cyc),
    .retired_cnt(c_ret));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] ent(input logic ov, input logic we, input logic [4:0] wa,
                                             input logic [31:0] pc, input logic [31:0] wd);
    return {ov, we, wa, pc[31:2], wd};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic ov, input logic pop);
    commit_valid = 1'b1; commit_pc = pc; gpr_we = we; gpr_waddr = wa; gpr_wdata = wd;
    ovf = ov; rd_req = pop;
    cyc();
    commit_valid = 1'b0; gpr_we = 1'b0; ovf = 1'b0; rd_req = 1'b0;
  endtask

  task automatic pop();
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; commit_valid = 1'b0; commit_pc = '0; gpr_we = 1'b0; gpr_waddr = '0;
    gpr_wdata = '0; ovf = 1'b0; bp_en = '0; bp_addr = '0; max_cycles = '0; clr = 1'b0;
    rd_req = 1'b0;
    cyc(); cyc();
    chk("rst_vld", a_vld, 0);
    chk("rst_level", a_lvl, 0);
    chk("rst_halt", a_halt, 0);
    chk("rst_cause", a_cause, 0);
    chk("rst_cyc", a_cyc, 0);
    chk("rst_data", a_dat, 0);
    rst = 1'b0;

    // 1: first write goes through the latch, the rest coincide with their commit
    gpr_we = 1'b1; gpr_waddr = 5'd1; gpr_wdata = 32'd1;
    cyc();
    gpr_we = 1'b0;
    commit(32'h3000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    for (int k = 2; k <= 5; k++)
      commit(32'h3000 + 32'(4*(k-1)), 1'b1, 5'(k), 32'(k), 1'b0, 1'b0);
    chk("t1_level", a_lvl, 5);
    chk("t1_retired", a_ret, 5);
    chk("t1_lost", a_lost, 0);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("t1_entry%0d", k), a_dat, ent(1'b0, 1'b1, 5'(k), 32'h3000 + 32'(4*(k-1)), 32'(k)));
      pop();
    end
    chk("t1_empty", a_vld, 0);
    do_clr();

    // 2: breakpoint on channel 2
    bp_addr[95:64] = 32'h3008; bp_en = 4'b0100;
    commit(32'h3000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    commit(32'h3004, 1'b1, 5'd2, 32'd2, 1'b0, 1'b0);
    chk("t2_nohalt", a_halt, 0);
    commit(32'h3008, 1'b1, 5'd3, 32'd3, 1'b0, 1'b0);
    chk("t2_halt", a_halt, 1);
    chk("t2_cause", a_cause, 3'b001);
    commit(32'h300C, 1'b1, 5'd4, 32'd4, 1'b0, 1'b0);
    chk("t2_level", a_lvl, 3);
    chk("t2_retired", a_ret, 3);
    chk("t2_e0", a_dat, ent(1'b0, 1'b0, 5'd0, 32'h3000, 32'd0));
    pop(); pop();
    chk("t2_last", a_dat, ent(1'b0, 1'b1, 5'd3, 32'h3008, 32'd3));
    pop();
    bp_en = '0;

    // 3: timeout at 300 cycles
    max_cycles = 16'd300;
    do_clr();
    chk("t3_clr_halt", a_halt, 0);
    repeat (299) cyc();
    chk("t3_pre_halt", a_halt, 0);
    chk("t3_pre_cyc", a_cyc, 299);
    cyc();
    chk("t3_halt", a_halt, 1);
    chk("t3_cause", a_cause, 3'b010);
    repeat (5) cyc();
    chk("t3_cyc_frozen", a_cyc, 299);
    max_cycles = '0;
    do_clr();

    // 4: six commits into the 4-deep buffers
    for (int k = 1; k <= 6; k++)
      commit(32'h4000 + 32'(4*(k-1)), 1'b1, 5'(k), 32'(k), 1'b0, 1'b0);
    chk("t4_b_level", b_lvl, 4);
    chk("t4_c_level", c_lvl, 4);
    chk("t4_b_lost", b_lost, 1);
    chk("t4_c_lost", c_lost, 1);
    chk("t4_a_lost", a_lost, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_b_entry%0d", i), b_dat, ent(1'b0, 1'b1, 5'(i+1), 32'h4000 + 32'(4*i), 32'(i+1)));
      chk($sformatf("t4_c_entry%0d", i), c_dat, ent(1'b0, 1'b1, 5'(i+3), 32'h4000 + 32'(4*(i+2)), 32'(i+3)));
      pop();
    end
    chk("t4_b_empty", b_vld, 0);
    do_clr();

    // 5: overflow and breakpoint in the same commit, then overflow alone
    bp_addr[31:0] = 32'h5000; bp_en = 4'b0001;
    commit(32'h5000, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
    chk("t5_halt", a_halt, 1);
    chk("t5_cause", a_cause, 3'b101);
    chk("t5_entry", a_dat, ent(1'b1, 1'b1, 5'd7, 32'h5000, 32'h77));
    do_clr();
    chk("t5_clr_halt", a_halt, 0);
    chk("t5_clr_level", a_lvl, 0);
    chk("t5_clr_cyc", a_cyc, 0);
    chk("t5_clr_ret", a_ret, 0);
    chk("t5_clr_cause", a_cause, 0);
    bp_en = '0;
    commit(32'h6000, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("t5_ovf_cause", a_cause, 3'b100);
    chk("t5_ovf_halt", a_halt, 1);
    do_clr();

    // 6: push+pop on empty and on full, then asynchronous reset while halted
    commit(32'h7000, 1'b1, 5'd1, 32'd1, 1'b0, 1'b1);
    chk("t6_empty_pp", b_lvl, 1);
    for (int k = 2; k <= 4; k++)
      commit(32'h7000 + 32'(4*(k-1)), 1'b1, 5'(k), 32'(k), 1'b0, 1'b0);
    chk("t6_full", b_lvl, 4);
    commit(32'h7010, 1'b1, 5'd5, 32'd5, 1'b0, 1'b1);
    chk("t6_full_pp_level", b_lvl, 4);
    chk("t6_full_pp_lost", b_lost, 0);
    chk("t6_full_pp_head", b_dat, ent(1'b0, 1'b1, 5'd2, 32'h7004, 32'd2));
    bp_en = 4'b0001;
    commit(32'h5000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("t6_halt", a_halt, 1);
    rst = 1'b1;
    #2;
    chk("t6_rst_halt", a_halt, 0);
    chk("t6_rst_level", a_lvl, 0);
    chk("t6_rst_vld", a_vld, 0);
    chk("t6_rst_data", a_dat, 0);
    chk("t6_rst_cause", a_cause, 0);
    chk("t6_rst_cyc", a_cyc, 0);
    chk("t6_rst_ret", a_ret, 0);
    chk("t6_rst_b_level", b_lvl, 0);
    cyc();
    rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
